// File: rtl/spill_header_sequencer_if.sv
// spill_header_sequencer_if: spill gate, trigger, checker feedback and per-spill status bundle
interface spill_header_sequencer_if #(
    parameter int NCH = 4
);
    logic              live_in;
    logic              trig_in;
    logic [NCH*16-1:0] in_counter_bus;
    logic [NCH-1:0]    evtno_err_vec;
    logic [NCH-1:0]    spillno_err_vec;
    logic              live_rising;
    logic [9:0]        exp_spillno;
    logic [15:0]       trig_count;
    logic              spill_done;
    logic [NCH-1:0]    err_evt_mask;
    logic [NCH-1:0]    err_spill_mask;
    logic [NCH-1:0]    cnt_mismatch_mask;
    logic              timeout_flag;
    logic              spill_ok;
    logic [15:0]       spill_count;

    modport master (
        input  live_in, trig_in, in_counter_bus, evtno_err_vec, spillno_err_vec,
        output live_rising, exp_spillno, trig_count, spill_done, err_evt_mask,
               err_spill_mask, cnt_mismatch_mask, timeout_flag, spill_ok, spill_count
    );

    modport slave (
        output live_in, trig_in, in_counter_bus, evtno_err_vec, spillno_err_vec,
        input  live_rising, exp_spillno, trig_count, spill_done, err_evt_mask,
               err_spill_mask, cnt_mismatch_mask, timeout_flag, spill_ok, spill_count
    );
endinterface

// File: rtl/spill_header_sequencer.sv
// spill_header_sequencer: per-spill sequencing of the OFC1 header checkers and error summary latch
module spill_header_sequencer #(
    parameter int          NCH           = 4,
    parameter logic [15:0] DRAIN_TIMEOUT = 16'd50000
) (
    input logic                      clk,
    input logic                      reset,
    spill_header_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, LIVE, DRAIN, CHECK} state_t;

    state_t         state, state_next;
    logic           live_s1, live_s2, live_d, rise, fall;
    logic           pending, drain_to, all_match;
    logic           go_live, go_drain, drain_exit, exit_to;
    logic [15:0]    timer;
    logic [NCH-1:0] mismatch;

    assign rise      = live_s2 && !live_d;
    assign fall      = !live_s2 && live_d;
    assign all_match = mismatch == '0;

    for (genvar i = 0; i < NCH; i++) begin : g_cmp
        assign mismatch[i] = bus.in_counter_bus[16*i +: 16] != bus.trig_count;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next state and single-cycle strobes; a rise in DRAIN aborts the drain as a timeout
    always_comb begin
        state_next = state;
        go_live    = 1'b0;
        go_drain   = 1'b0;
        drain_exit = 1'b0;
        exit_to    = 1'b0;
        case (state)
            IDLE: begin
                go_live    = rise || pending;
                state_next = go_live ? LIVE : IDLE;
            end
            LIVE: begin
                go_drain   = fall;
                state_next = fall ? DRAIN : LIVE;
            end
            DRAIN: begin
                drain_exit = rise || all_match || timer == DRAIN_TIMEOUT - 16'd1;
                exit_to    = rise || !all_match;
                state_next = drain_exit ? CHECK : DRAIN;
            end
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // synchronizer, trigger counting, drain timer and per-spill status latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {live_s1, live_s2, live_d, pending, drain_to} <= '0;
            timer                 <= '0;
            bus.live_rising       <= 1'b0;
            bus.exp_spillno       <= 10'h3FF;
            bus.trig_count        <= '0;
            bus.spill_done        <= 1'b0;
            bus.err_evt_mask      <= '0;
            bus.err_spill_mask    <= '0;
            bus.cnt_mismatch_mask <= '0;
            bus.timeout_flag      <= 1'b0;
            bus.spill_ok          <= 1'b0;
            bus.spill_count       <= '0;
        end else begin
            live_s1         <= bus.live_in;
            live_s2         <= live_s1;
            live_d          <= live_s2;
            bus.live_rising <= go_live;
            bus.spill_done  <= state == CHECK;
            pending         <= go_live ? 1'b0 : pending || (rise && (state == DRAIN || state == CHECK));
            timer           <= go_drain ? '0 : state == DRAIN ? timer + 16'd1 : timer;
            if (go_live) begin
                bus.exp_spillno <= bus.exp_spillno + 10'd1;
                bus.trig_count  <= '0;
            end else if (state == LIVE && bus.trig_in && !bus.live_rising && bus.trig_count != 16'hFFFF)
                bus.trig_count <= bus.trig_count + 16'd1;
            if (drain_exit)
                drain_to <= exit_to;
            if (state == CHECK) begin
                bus.err_evt_mask      <= bus.evtno_err_vec;
                bus.err_spill_mask    <= bus.spillno_err_vec;
                bus.cnt_mismatch_mask <= mismatch;
                bus.timeout_flag      <= drain_to;
                bus.spill_ok          <= !drain_to && all_match && bus.evtno_err_vec == '0 && bus.spillno_err_vec == '0;
                bus.spill_count       <= bus.spill_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_spill_header_sequencer.sv
// tb_spill_header_sequencer: vector table, directed corner sequences and randomized spills vs a spill-level model
module tb_spill_header_sequencer;
    localparam int NCH = 4;
    localparam int DT  = 40;

    typedef struct {
        int       live_len;
        int       ntrig;
        logic [3:0] stuck;
        logic [3:0] ee;
        logic [3:0] se;
        logic [3:0] cnt_mask;
        logic     to;
        logic     ok;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, errors = 0;
    int done_cnt = 0, rise_cnt = 0, exp_done = 0, exp_rise = 0;
    int sent, n, lat;
    int lats [5];
    logic [9:0]  exp_sn = 10'h3FF;
    logic [15:0] exp_sc = '0;
    logic [3:0]  st_evt = '0, st_spill = '0, st_cnt = '0;
    logic        st_to = 1'b0, st_ok = 1'b0;
    vec_t tbl [5];
    vec_t v;

    spill_header_sequencer_if #(.NCH(NCH)) bus ();

    spill_header_sequencer #(.NCH(NCH), .DRAIN_TIMEOUT(16'(DT))) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.spill_done) done_cnt++;
        if (bus.live_rising) rise_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] counters(input int s, input logic [3:0] stuck);
        logic [63:0] r;
        for (int i = 0; i < NCH; i++) r[16*i +: 16] = stuck[i] ? 16'(s - 1) : 16'(s);
        return r;
    endfunction

    task automatic check_status();
        check("err_evt_mask", bus.err_evt_mask, st_evt);
        check("err_spill_mask", bus.err_spill_mask, st_spill);
        check("cnt_mismatch_mask", bus.cnt_mismatch_mask, st_cnt);
        check("timeout_flag", bus.timeout_flag, st_to);
        check("spill_ok", bus.spill_ok, st_ok);
        check("spill_count", bus.spill_count, exp_sc);
    endtask

    task automatic model_reset();
        exp_sn = 10'h3FF;
        exp_sc = '0;
        {st_evt, st_spill, st_cnt, st_to, st_ok} = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_live_rising"}, bus.live_rising, 0);
        check({tag, "_spill_done"}, bus.spill_done, 0);
        check({tag, "_exp_spillno"}, bus.exp_spillno, 10'h3FF);
        check({tag, "_trig_count"}, bus.trig_count, 0);
        check_status();
    endtask

    // raise live, expect the checker reset pulse 3 edges later; a trigger in the pulse cycle is not counted
    task automatic start_spill();
        int k = 0;
        bus.live_in = 1'b1;
        bus.in_counter_bus = '0;
        do begin
            step(1);
            k++;
        end while (!bus.live_rising && k < 10);
        exp_sn++;
        exp_rise++;
        check("rise_latency", k, 3);
        check("exp_spillno", bus.exp_spillno, exp_sn);
        check("trig_count_clear", bus.trig_count, 0);
        check_status();
        bus.trig_in = 1'b1;
        step(1);
        bus.trig_in = 1'b0;
        check("live_rising_width", bus.live_rising, 0);
    endtask

    task automatic live_phase(input int len, input int ntrig, output int s);
        s = 0;
        for (int c = 0; c < len; c++) begin
            bus.trig_in = s < ntrig && (len - c <= ntrig - s || $urandom_range(0, 2) == 0);
            if (bus.trig_in) s++;
            step(1);
        end
        bus.trig_in = 1'b0;
    endtask

    // drop live; a trigger in the fall-detect cycle counts, later ones are noise to be ignored
    task automatic end_phase(inout int s, input logic [3:0] stuck, input logic [3:0] ee,
                             input logic [3:0] se, output int l);
        bus.live_in = 1'b0;
        bus.evtno_err_vec = ee;
        bus.spillno_err_vec = se;
        step(2);
        bus.trig_in = 1'b1;
        s++;
        bus.in_counter_bus = counters(s, stuck);
        l = 2;
        do begin
            step(1);
            l++;
            bus.trig_in = 1'($urandom_range(0, 1));
        end while (!bus.spill_done && l < DT + 20);
        bus.trig_in = 1'b0;
    endtask

    task automatic finish_checks(input int s, input logic [3:0] cm, input logic to,
                                 input logic ok, input logic [3:0] ee, input logic [3:0] se);
        check("spill_done", bus.spill_done, 1);
        st_evt = ee;
        st_spill = se;
        st_cnt = cm;
        st_to = to;
        st_ok = ok;
        exp_sc++;
        exp_done++;
        check_status();
        check("trig_count", bus.trig_count, s);
        bus.evtno_err_vec = '0;
        bus.spillno_err_vec = '0;
        step(1);
        check("spill_done_width", bus.spill_done, 0);
    endtask

    task automatic run_vec(input vec_t x, output int l);
        int s;
        start_spill();
        live_phase(x.live_len, x.ntrig, s);
        end_phase(s, x.stuck, x.ee, x.se, l);
        finish_checks(s, x.cnt_mask, x.to, x.ok, x.ee, x.se);
    endtask

    initial begin
        tbl[0] = '{100, 9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[1] = '{60, 9, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0};
        tbl[2] = '{50, 5, 4'b0000, 4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0};
        tbl[3] = '{30, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[4] = '{40, 19, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 1'b1, 1'b0};
        bus.live_in = 1'b0;
        bus.trig_in = 1'b0;
        bus.in_counter_bus = '0;
        bus.evtno_err_vec = '0;
        bus.spillno_err_vec = '0;
        step(2);
        check_reset("in_reset");
        reset = 1'b0;
        step(3);
        check_reset("after_reset");

        for (int i = 0; i < 5; i++) run_vec(tbl[i], lats[i]);
        check("timeout_extra_cycles", lats[1] - lats[0], DT - 1);

        // live re-rises during DRAIN: forced timeout, then the pending spill starts
        start_spill();
        live_phase(20, 4, sent);
        bus.live_in = 1'b0;
        step(2);
        bus.trig_in = 1'b1;
        sent++;
        bus.in_counter_bus = counters(sent, 4'b1111);
        step(1);
        bus.trig_in = 1'b0;
        step(4);
        bus.live_in = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.spill_done && n < 10);
        check("rerise_done_latency", n, 4);
        finish_checks(sent, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000);
        check("rerise_live_rising", bus.live_rising, 1);
        exp_sn++;
        exp_rise++;
        check("rerise_exp_spillno", bus.exp_spillno, exp_sn);
        step(1);
        check("rerise_live_rising_width", bus.live_rising, 0);
        bus.in_counter_bus = '0;
        live_phase(15, 2, sent);
        end_phase(sent, 4'b0000, 4'b0000, 4'b0000, lat);
        finish_checks(sent, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000);

        // randomized spills against the spill-level model
        for (int i = 0; i < 20; i++) begin
            v.live_len = $urandom_range(20, 60);
            v.ntrig = $urandom_range(0, 15);
            v.stuck = $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 15)) : 4'b0000;
            v.ee = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000;
            v.se = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000;
            v.cnt_mask = v.stuck;
            v.to = v.stuck != 0;
            v.ok = (v.stuck | v.ee | v.se) == 0;
            run_vec(v, lat);
        end

        // asynchronous reset in the middle of LIVE
        start_spill();
        live_phase(10, 3, sent);
        n = done_cnt;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset("mid_live_reset");
        bus.live_in = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        check_reset("mid_live_released");
        check("mid_live_no_done", done_cnt, n);

        // 1025 back-to-back spills: spill number wraps after 1023
        for (int i = 0; i < 1025; i++) begin
            start_spill();
            live_phase(2, 0, sent);
            end_phase(sent, 4'b0000, 4'b0000, 4'b0000, lat);
            finish_checks(sent, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000);
        end
        check("spill_count_1025", bus.spill_count, 1025);
        check("exp_spillno_wrapped", bus.exp_spillno, 0);
        step(2);
        check("total_spill_done_pulses", done_cnt, exp_done);
        check("total_live_rising_pulses", rise_cnt, exp_rise);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
